// File: rtl/mosq_pkg.sv
// Shared types and width helpers for the mosquito zapper control slice.
package mosq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_CONFIRM  = 3'd2,
    ST_FIRE     = 3'd3,
    ST_COOLDOWN = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  // Bits needed to hold any value in 0..max_count.
  function automatic int cnt_w(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic int prescale_w(input int div);
    return cnt_w(div - 1);
  endfunction

  function automatic int confirm_w(input int samples);
    return cnt_w(samples);
  endfunction

  function automatic int cooldown_w(input int samples);
    return cnt_w(samples);
  endfunction

  function automatic int timeout_w(input int cycles);
    return cnt_w(cycles);
  endfunction

endpackage

// File: rtl/mosq_sample_tick.sv
// Sample-strobe prescaler: counts 0..SAMPLE_DIV-1 while enabled and emits a
// registered one-cycle det_en when the count sits at its last value.
// clr is synchronous and wins over en, so no strobe leaks out on the edge
// where the owner goes idle.
module mosq_sample_tick
  import mosq_pkg::*;
#(
  parameter int SAMPLE_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic det_en
);

  localparam int PW = prescale_w(SAMPLE_DIV);
  localparam logic [PW-1:0] LAST = PW'(SAMPLE_DIV - 1);

  logic [PW-1:0] cnt;

  // Free-running divider with a registered terminal-count strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      det_en <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      det_en <= 1'b0;
    end else if (en) begin
      det_en <= (cnt == LAST);
      cnt    <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end else begin
      det_en <= 1'b0;
    end
  end

endmodule

// File: rtl/mosq_zap_ctrl.sv
// Mosquito detector / zapper sequencer: strobes the detector, qualifies
// is_mosq over consecutive samples, runs the fire_req/fire_ack handshake and
// a cooldown. Define MOSQ_ACK_TIMEOUT_EN to add an ack timeout that latches
// a FAULT state cleared by clear_fault.
module mosq_zap_ctrl
  import mosq_pkg::*;
#(
  parameter int SAMPLE_DIV       = 16,
  parameter int CONFIRM_SAMPLES  = 3,
  parameter int COOLDOWN_SAMPLES = 64,
  parameter int ACK_TIMEOUT      = 1024,
  parameter int CNT_W            = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               is_mosq,
  output logic               det_en,
  output logic               fire_req,
  input  logic               fire_ack,
  input  logic               clear_fault,
  output logic [STATE_W-1:0] state,
  output logic               busy,
  output logic               fault,
  output logic [CNT_W-1:0]   zap_cnt
);

  localparam int CW = confirm_w(CONFIRM_SAMPLES);
  localparam int DW = cooldown_w(COOLDOWN_SAMPLES);

  state_t          state_q, state_d;
  logic [CW-1:0]   conf_cnt, conf_d;
  logic [DW-1:0]   cool_cnt, cool_d;
  logic [CNT_W-1:0] zap_d;
  logic            tick_en, tick_clr;

`ifdef MOSQ_ACK_TIMEOUT_EN
  localparam int TW = timeout_w(ACK_TIMEOUT);
  logic [TW-1:0] to_cnt, to_d;
`endif

  assign state = state_q;

  // Prescaler runs only while active; clearing on the transition edge keeps
  // det_en quiet in IDLE/FAULT and restarts the phase on re-entry.
  assign tick_en  = (state_q != ST_IDLE) && (state_q != ST_FAULT);
  assign tick_clr = (state_d == ST_IDLE) || (state_d == ST_FAULT);

  mosq_sample_tick #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (tick_en),
    .clr   (tick_clr),
    .det_en(det_en)
  );

  // Next-state, counter and handshake decisions; disarm beats a sample.
  always_comb begin
    state_d = state_q;
    conf_d  = conf_cnt;
    cool_d  = cool_cnt;
    zap_d   = zap_cnt;
`ifdef MOSQ_ACK_TIMEOUT_EN
    to_d    = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!arm) begin
          state_d = ST_IDLE;
        end else if (det_en && is_mosq) begin
          if (CONFIRM_SAMPLES == 1) begin
            state_d = ST_FIRE;
          end else begin
            state_d = ST_CONFIRM;
            conf_d  = CW'(1);
          end
        end
      end
      ST_CONFIRM: begin
        if (!arm) begin
          state_d = ST_IDLE;
          conf_d  = '0;
        end else if (det_en) begin
          if (!is_mosq) begin
            state_d = ST_ARMED;
            conf_d  = '0;
          end else if (conf_cnt == CW'(CONFIRM_SAMPLES - 1)) begin
            state_d = ST_FIRE;
            conf_d  = '0;
          end else begin
            conf_d = conf_cnt + CW'(1);
          end
        end
      end
      ST_FIRE: begin
        // Disarm is held off until the actuator acknowledges.
        if (fire_ack) begin
          if (zap_cnt != '1) zap_d = zap_cnt + CNT_W'(1);
          state_d = arm ? ST_COOLDOWN : ST_IDLE;
        end
`ifdef MOSQ_ACK_TIMEOUT_EN
        else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
          state_d = ST_FAULT;
        end else begin
          to_d = to_cnt + TW'(1);
        end
`endif
      end
      ST_COOLDOWN: begin
        if (!arm) begin
          state_d = ST_IDLE;
          cool_d  = '0;
        end else if (det_en) begin
          if (cool_cnt == DW'(COOLDOWN_SAMPLES - 1)) begin
            state_d = ST_ARMED;
            cool_d  = '0;
          end else begin
            cool_d = cool_cnt + DW'(1);
          end
        end
      end
`ifdef MOSQ_ACK_TIMEOUT_EN
      ST_FAULT: begin
        if (clear_fault) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered status outputs derived from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      conf_cnt <= '0;
      cool_cnt <= '0;
      zap_cnt  <= '0;
      fire_req <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      conf_cnt <= conf_d;
      cool_cnt <= cool_d;
      zap_cnt  <= zap_d;
      fire_req <= (state_d == ST_FIRE);
      busy     <= (state_d inside {ST_CONFIRM, ST_FIRE, ST_COOLDOWN});
    end
  end

`ifdef MOSQ_ACK_TIMEOUT_EN
  // Ack timeout counter and latched fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      fault  <= 1'b0;
    end else begin
      to_cnt <= to_d;
      fault  <= (state_d == ST_FAULT);
    end
  end
`else
  // Without the timeout there is no fault path at all.
  logic unused_cfg;
  assign unused_cfg = clear_fault ^ (ACK_TIMEOUT < 1);
  assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_mosq_zap_ctrl.sv
// Self-checking bench for mosq_zap_ctrl: directed scenarios followed by a
// randomized run, every cycle compared with a behavioural model.
module tb_mosq_zap_ctrl;

  localparam int SAMPLE_DIV       = 4;
  localparam int CONFIRM_SAMPLES  = 3;
  localparam int COOLDOWN_SAMPLES = 2;
  localparam int ACK_TIMEOUT      = 16;
  localparam int CNT_W            = 2;
  localparam int ZAP_MAX          = (1 << CNT_W) - 1;
`ifdef MOSQ_ACK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             arm;
  logic             is_mosq;
  logic             det_en;
  logic             fire_req;
  logic             fire_ack;
  logic             clear_fault;
  logic [2:0]       state;
  logic             busy;
  logic             fault;
  logic [CNT_W-1:0] zap_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: mode uses the externally visible state codes.
  int m_mode, m_hits, m_cool, m_wait, m_zaps, m_phase, m_det;

  mosq_zap_ctrl #(
    .SAMPLE_DIV      (SAMPLE_DIV),
    .CONFIRM_SAMPLES (CONFIRM_SAMPLES),
    .COOLDOWN_SAMPLES(COOLDOWN_SAMPLES),
    .ACK_TIMEOUT     (ACK_TIMEOUT),
    .CNT_W           (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .is_mosq    (is_mosq),
    .det_en     (det_en),
    .fire_req   (fire_req),
    .fire_ack   (fire_ack),
    .clear_fault(clear_fault),
    .state      (state),
    .busy       (busy),
    .fault      (fault),
    .zap_cnt    (zap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_hits = 0; m_cool = 0; m_wait = 0;
    m_zaps = 0; m_phase = 0; m_det = 0;
  endtask

  // One clock of the reference behaviour, using inputs present at the edge.
  task automatic model_step();
    int nm;
    bit samp;
    if (rst) begin
      model_reset();
      return;
    end
    samp = (m_det != 0);
    nm = m_mode;
    case (m_mode)
      0: if (arm) nm = 1;
      1: begin
        if (!arm) nm = 0;
        else if (samp && is_mosq) begin
          m_hits = 1;
          nm = (m_hits >= CONFIRM_SAMPLES) ? 3 : 2;
        end
      end
      2: begin
        if (!arm) nm = 0;
        else if (samp) begin
          if (is_mosq) begin
            m_hits++;
            if (m_hits >= CONFIRM_SAMPLES) nm = 3;
          end else nm = 1;
        end
      end
      3: begin
        if (fire_ack) begin
          if (m_zaps < ZAP_MAX) m_zaps++;
          nm = arm ? 4 : 0;
        end else if (TO_EN) begin
          m_wait++;
          if (m_wait >= ACK_TIMEOUT) nm = 5;
        end
      end
      4: begin
        if (!arm) nm = 0;
        else if (samp) begin
          m_cool++;
          if (m_cool >= COOLDOWN_SAMPLES) nm = 1;
        end
      end
      default: if (clear_fault) nm = 0;
    endcase
    if (nm != 2) m_hits = 0;
    if (nm != 4) m_cool = 0;
    if (nm != 3) m_wait = 0;
    // Strobe on every SAMPLE_DIV-th cycle spent active.
    if (nm == 0 || nm == 5) begin
      m_phase = 0; m_det = 0;
    end else if (m_mode == 0 || m_mode == 5) begin
      m_det = 0;
    end else begin
      m_phase++;
      m_det = ((m_phase % SAMPLE_DIV) == 0) ? 1 : 0;
    end
    m_mode = nm;
  endtask

  task automatic compare_all();
    check("state", state, m_mode);
    check("det_en", det_en, m_det);
    check("fire_req", fire_req, (m_mode == 3) ? 1 : 0);
    check("busy", busy, (m_mode >= 2 && m_mode <= 4) ? 1 : 0);
    check("fault", fault, (m_mode == 5) ? 1 : 0);
    check("zap_cnt", zap_cnt, m_zaps);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wait_state(input int s, input int limit, input string tag);
    int n = 0;
    while (state !== 3'(s) && n < limit) begin
      tick();
      n++;
    end
    check(tag, state, s);
  endtask

  // Present one is_mosq value for the next det_en sample.
  task automatic sample(input bit m);
    int n = 0;
    is_mosq = m;
    while (det_en !== 1'b1 && n < 4 * SAMPLE_DIV) begin
      tick();
      n++;
    end
    check("sample_wait", det_en, 1);
    tick();
    is_mosq = 1'b0;
  endtask

  task automatic ack_once();
    fire_ack = 1'b1;
    tick();
    fire_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; is_mosq = 1'b0; fire_ack = 1'b0; clear_fault = 1'b0;
    model_reset();
    #1;
    compare_all();
    tick();
    tick();
    rst = 1'b0;

    // Disarmed: nothing moves.
    repeat (100) tick();
    check("idle_state", state, 0);

    // Arm and verify strobe phase.
    arm = 1'b1;
    tick();
    check("armed_state", state, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("strobe_phase", det_en, (i % SAMPLE_DIV == 0) ? 1 : 0);
    end

    // Three hits fire; ack completes; cooldown returns to ARMED.
    for (int i = 0; i < 3; i++) sample(1'b1);
    check("fire_state", state, 3);
    check("fire_req_on", fire_req, 1);
    repeat (4) tick();
    ack_once();
    check("fire_req_off", fire_req, 0);
    check("zap_one", zap_cnt, 1);
    check("cooldown_state", state, 4);
    wait_state(1, 4 * SAMPLE_DIV, "cooldown_exit");

    // Broken streak returns to ARMED, full streak fires.
    sample(1'b1); sample(1'b1); sample(1'b0);
    check("streak_broken", state, 1);
    check("streak_no_req", fire_req, 0);
    for (int i = 0; i < 3; i++) sample(1'b1);
    check("streak_fire", state, 3);
    ack_once();
    wait_state(1, 4 * SAMPLE_DIV, "cooldown_exit2");

    // Disarm during FIRE is deferred until ack.
    for (int i = 0; i < 3; i++) sample(1'b1);
    arm = 1'b0;
    repeat (3) tick();
    check("deferred_req", fire_req, 1);
    check("deferred_state", state, 3);
    ack_once();
    check("disarm_after_ack", state, 0);
    check("zap_three", zap_cnt, 3);

    // Saturation of zap_cnt.
    for (int k = 0; k < 2; k++) begin
      arm = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) sample(1'b1);
      ack_once();
      wait_state(1, 4 * SAMPLE_DIV, "sat_cooldown_exit");
    end
    check("zap_saturated", zap_cnt, ZAP_MAX);

    // Asynchronous reset in the middle of FIRE.
    for (int i = 0; i < 3; i++) sample(1'b1);
    check("pre_reset_fire", state, 3);
    #2;
    rst = 1'b1;
    #1;
    check("async_req_drop", fire_req, 0);
    check("async_state", state, 0);
    check("async_zap", zap_cnt, 0);
    model_reset();
    tick();
    rst = 1'b0;
    wait_state(1, 4, "rearm_after_reset");

    // Ack timeout behaviour.
    for (int i = 0; i < 3; i++) sample(1'b1);
    check("to_fire", state, 3);
    if (TO_EN) begin
      repeat (ACK_TIMEOUT) tick();
      check("to_state", state, 5);
      check("to_fault", fault, 1);
      check("to_req", fire_req, 0);
      check("to_zap", zap_cnt, 0);
      repeat (3) tick();
      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      check("clear_state", state, 0);
      check("clear_fault", fault, 0);
      tick();
      check("rearm_state", state, 1);
      for (int i = 0; i < 3; i++) sample(1'b1);
      repeat (ACK_TIMEOUT - 1) tick();
      ack_once();
      check("late_ack_state", state, 4);
      check("late_ack_zap", zap_cnt, 1);
    end else begin
      repeat (1000) tick();
      check("wait_req", fire_req, 1);
      check("wait_fault", fault, 0);
      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      check("clear_ignored", state, 3);
      ack_once();
      check("wait_ack_zap", zap_cnt, 1);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 499) == 0);
      arm         = ($urandom_range(0, 31) != 0);
      is_mosq     = ($urandom_range(0, 9) < 6);
      fire_ack    = ($urandom_range(0, 3) == 0);
      clear_fault = ($urandom_range(0, 15) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mosq_zap_ctrl.md
Name: mosq_zap_ctrl

Overview:
Sequencer for the mosquito detector and the zapper actuator.
- Generates the detector's sample strobe (det_en, wired to the detector's in_en).
- Qualifies the detector's is_mosq flag over several samples.
- Runs a req/ack fire handshake with the actuator, then enforces a cooldown.
- Sits between the detector datapath and the actuator driver; armed and disarmed by the system control logic.

Parameters:
SAMPLE_DIV, 16, clk cycles per det_en strobe; legal values >= 2
CONFIRM_SAMPLES, 3, consecutive is_mosq=1 samples required to fire; legal values >= 1
COOLDOWN_SAMPLES, 64, samples to wait after a completed fire; legal values >= 1
ACK_TIMEOUT, 1024, max cycles fire_req may wait for fire_ack (optional feature only)
CNT_W, 8, width of zap_cnt

Ports:
clk  in  1  clock
rst  in  1  reset
arm  in  1  level; 1 = enable detection/firing
is_mosq  in  1  registered detection flag from the detector
det_en  out  1  single-cycle sample strobe to the detector
fire_req  out  1  fire request to the actuator
fire_ack  in  1  actuator acknowledge
clear_fault  in  1  single-cycle fault clear
state  out  3  current FSM state code
busy  out  1  state is CONFIRM, FIRE or COOLDOWN
fault  out  1  ack timeout latched
zap_cnt  out  CNT_W  completed-fire count

Behaviour:
- Reset and clock: reset rst, asynchronous, active-high; clock clk. Under reset, all outputs are 0 and state is IDLE.
- State codes: IDLE=0, ARMED=1, CONFIRM=2, FIRE=3, COOLDOWN=4, FAULT=5.
- Prescaler:
  - Held at 0 in IDLE and FAULT.
  - In all other states it counts 0..SAMPLE_DIV-1 and wraps.
  - det_en is registered and high for exactly one cycle when the count equals SAMPLE_DIV-1. The first strobe comes SAMPLE_DIV cycles after leaving IDLE.
  - A "sample" is a cycle with det_en=1; is_mosq is evaluated only in sample cycles.
- IDLE: arm=1 -> ARMED.
- ARMED:
  - Sample with is_mosq=1 -> CONFIRM with conf_cnt=1.
  - If CONFIRM_SAMPLES==1, that sample goes directly to FIRE.
- CONFIRM:
  - Sample with is_mosq=1 increments conf_cnt; reaching CONFIRM_SAMPLES -> FIRE.
  - Sample with is_mosq=0 clears conf_cnt -> ARMED.
- FIRE:
  - fire_req=1, registered, asserted the cycle FIRE is entered, and held until fire_ack=1 is sampled.
  - On ack: zap_cnt increments, saturating at all-ones, cleared only by rst. fire_req=0 the next cycle.
  - After ack, go to COOLDOWN if arm=1, else IDLE.
- COOLDOWN:
  - Counts COOLDOWN_SAMPLES samples, then -> ARMED with conf_cnt=0.
  - is_mosq is ignored.
- Disarm:
  - arm=0 in ARMED, CONFIRM or COOLDOWN -> IDLE next cycle; conf_cnt and cooldown count are cleared.
  - In FIRE, disarm is deferred until ack; a handshake is never abandoned.
- Actuator input: fire_ack outside FIRE is ignored.
- Simultaneous events: arm=0 and a qualifying sample in the same cycle -> disarm wins (IDLE).
- Status: busy and fault are registered, consistent with state.
- Mid-operation reset: rst during FIRE drops fire_req immediately (asynchronous) and does not increment zap_cnt.

Optional Feature:
MOSQ_ACK_TIMEOUT_EN
- Defined:
  - A cycle counter runs in FIRE.
  - If ACK_TIMEOUT cycles elapse without fire_ack -> FAULT: fire_req=0, fault=1, zap_cnt unchanged.
  - FAULT exits only on clear_fault=1 -> IDLE, fault=0, regardless of arm. A re-arm then follows the normal IDLE rule.
  - fire_ack arriving in the same cycle the timeout expires counts as success.
- Undefined: no counter is instantiated, FAULT is unreachable, fault is tied 0, clear_fault is ignored, and FIRE waits indefinitely.

Decomposition:
- Package mosq_pkg:
  - 3-bit state typedef/enum with the codes above.
  - STATE_W constant.
  - $clog2-derived width helpers for the prescaler, confirm, cooldown and timeout counters.
- Sub-module mosq_sample_tick: prescaler with enable and synchronous clear; outputs det_en. Reusable by other detector channels.
- FSM, confirm/cooldown counters and the handshake stay in mosq_zap_ctrl.

Test Plan:
(Parameters for all scenarios: SAMPLE_DIV=4, CONFIRM_SAMPLES=3, COOLDOWN_SAMPLES=2, ACK_TIMEOUT=16.)
1. rst, then arm=0 for 100 cycles -> det_en never high; state=0; all outputs 0.
2. arm=1 -> state=1 next cycle; det_en single-cycle pulses every 4 cycles, first pulse 4 cycles after entering ARMED.
3. is_mosq=1 on 3 samples -> state=3 and fire_req=1 the cycle after the 3rd sample; ack 5 cycles later -> fire_req=0 next cycle, zap_cnt=1, state=4; ARMED again after 2 more samples.
4. is_mosq samples 1,1,0 -> back to ARMED, no fire_req; then samples 1,1,1 -> fire.
5. arm=0 during FIRE -> fire_req held until ack; then state=0, zap_cnt incremented; with CNT_W=2 and 5 fires, zap_cnt=3 (saturated).
6. With MOSQ_ACK_TIMEOUT_EN defined: no ack for 16 cycles -> state=5, fault=1, fire_req=0; clear_fault -> state=0. Without the macro: fire_req stays 1 for 1000 cycles and fault=0.
